// File: rtl/btb_ras_predictor_pkg.sv
// Shared encodings and helpers for the BTB + return-address-stack predictor.
package btb_ras_predictor_pkg;

  localparam logic [1:0] BR   = 2'b00;
  localparam logic [1:0] JMP  = 2'b01;
  localparam logic [1:0] CALL = 2'b10;
  localparam logic [1:0] RET  = 2'b11;

  localparam logic [1:0] CTR_RST   = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_ras_predictor_ras_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest entry,
// popping when empty is ignored.
module ras_stack
  import btb_ras_predictor_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int SP_W  = clog2(DEPTH);
  localparam int CNT_W = SP_W + 1;

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SP_W-1:0]  sp_inc;

  // sp points at the current top entry; a push writes one slot above it.
  assign sp_inc = sp_q + SP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      sp_q          <= sp_inc;
      mem_q[sp_inc] <= push_data;
      if (cnt_q != CNT_W'(DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && (cnt_q != '0)) begin
      sp_q  <= sp_q - SP_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign top   = mem_q[sp_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/btb_ras_predictor.sv
// Direct-mapped BTB with 2-bit counters and type tags, plus a resolve-time RAS.
// Lookup is combinational on lk_pc; updates from EX land on the clock edge.
module btb_ras_predictor
  import btb_ras_predictor_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_all,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [1:0]      pred_type,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic [1:0]      upd_type
);

  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       type_q   [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, upd_alloc;
  logic [1:0]       ctr_cur, ctr_next;
  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;
  logic             unused_lk_bits;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign unused_lk_bits = ^lk_pc[1:0];

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // A not-taken BR that misses never earns a BTB slot.
  assign upd_alloc = !upd_hit && (upd_taken || (upd_type != BR));

  always_comb begin
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    pred_type   = 2'b00;
    if (lk_hit) begin
      pred_valid  = 1'b1;
      pred_type   = type_q[lk_idx];
      pred_taken  = (type_q[lk_idx] == BR) ? ctr_q[lk_idx][1] : 1'b1;
      pred_target = ((type_q[lk_idx] == RET) && !ras_empty) ? ras_top : target_q[lk_idx];
    end
  end

  always_comb begin
    ctr_cur  = ctr_q[upd_idx];
    ctr_next = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        type_q[i]   <= 2'b00;
        ctr_q[i]    <= CTR_RST;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_type == BR) ctr_q[upd_idx] <= ctr_next;
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
          type_q[upd_idx]   <= upd_type;
        end
      end else if (upd_alloc) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        type_q[upd_idx]   <= upd_type;
        ctr_q[upd_idx]    <= CTR_ALLOC;
      end
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_all),
    .push      (upd_valid && (upd_type == CALL)),
    .push_data (upd_pc + XLEN'(4)),
    .pop       (upd_valid && (upd_type == RET)),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_btb_ras_predictor.sv
// Directed plus randomized bench for btb_ras_predictor against a queue/array reference model.
module tb_btb_ras_predictor;
  import btb_ras_predictor_pkg::*;

  localparam int XLEN      = 32;
  localparam int ENTRIES   = 16;
  localparam int RAS_DEPTH = 4;
  localparam int IDX_W     = $clog2(ENTRIES);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_all = 1'b0;
  logic [XLEN-1:0] lk_pc = '0;
  logic            pred_valid, pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [1:0]      pred_type;
  logic            upd_valid = 1'b0;
  logic [XLEN-1:0] upd_pc = '0, upd_target = '0;
  logic            upd_taken = 1'b0;
  logic [1:0]      upd_type = 2'b00;

  btb_ras_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_all(flush_all), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_type(pred_type), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_type(upd_type)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: one record per slot remembering the owning PC, plus RAS as a queue (front = top)
  bit              m_valid [ENTRIES];
  logic [XLEN-1:0] m_pc    [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  logic [1:0]      m_ty    [ENTRIES];
  int              m_ctr   [ENTRIES];
  logic [XLEN-1:0] m_ras   [$];

  logic [XLEN-1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit model_hit(input logic [XLEN-1:0] pc);
    int s;
    s = slot_of(pc);
    return m_valid[s] && ((m_pc[s] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_ty[i] = BR; m_ctr[i] = 1;
    end
    m_ras.delete();
  endtask

  task automatic model_apply(input logic uv, input logic [XLEN-1:0] upc, input logic [XLEN-1:0] utgt,
                             input logic utk, input logic [1:0] uty, input logic fl, input logic rs);
    int s;
    s = slot_of(upc);
    if (rs) model_reset();
    else if (fl) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      m_ras.delete();
    end else if (uv) begin
      if (model_hit(upc)) begin
        if (uty == BR) m_ctr[s] = utk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                      : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
        if (utk) begin m_tgt[s] = utgt; m_ty[s] = uty; end
      end else if (utk || uty != BR) begin
        m_valid[s] = 1; m_pc[s] = upc; m_tgt[s] = utgt; m_ty[s] = uty; m_ctr[s] = 2;
      end
      if (uty == CALL) begin
        m_ras.push_front(upc + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_back());
      end else if (uty == RET && m_ras.size() > 0) void'(m_ras.pop_front());
    end
  endtask

  // scoreboard: queue the model's view of the current lookup, then compare against the DUT
  task automatic check_outputs(input logic [XLEN-1:0] lk);
    int s;
    logic [XLEN-1:0] e_v, e_tk, e_tgt, e_ty;
    s = slot_of(lk);
    e_v = '0; e_tk = '0; e_tgt = '0; e_ty = '0;
    if (model_hit(lk)) begin
      e_v   = 1;
      e_ty  = XLEN'(m_ty[s]);
      e_tk  = (m_ty[s] == BR) ? XLEN'(m_ctr[s] >= 2) : 1;
      e_tgt = (m_ty[s] == RET && m_ras.size() > 0) ? m_ras[0] : m_tgt[s];
    end
    exp_q.push_back(e_v); exp_q.push_back(e_tk); exp_q.push_back(e_tgt); exp_q.push_back(e_ty);
    check("pred_valid",  XLEN'(pred_valid), exp_q.pop_front());
    check("pred_taken",  XLEN'(pred_taken), exp_q.pop_front());
    check("pred_target", pred_target,       exp_q.pop_front());
    check("pred_type",   XLEN'(pred_type),  exp_q.pop_front());
  endtask

  // driver: inputs set just after a posedge, outputs sampled at the negedge, model advanced at the next posedge
  task automatic step(input logic uv, input logic [XLEN-1:0] upc, input logic [XLEN-1:0] utgt,
                      input logic utk, input logic [1:0] uty, input logic fl, input logic rs,
                      input logic [XLEN-1:0] lk);
    rst = rs; flush_all = fl; upd_valid = uv; upd_pc = upc; upd_target = utgt;
    upd_taken = utk; upd_type = uty; lk_pc = lk;
    #4;
    check_outputs(lk);
    @(posedge clk);
    model_apply(uv, upc, utgt, utk, uty, fl, rs);
    #1;
  endtask

  task automatic upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic tk,
                     input logic [1:0] ty);
    step(1'b1, pc, tgt, tk, ty, 1'b0, 1'b0, pc);
  endtask

  task automatic look(input string tag, input logic [XLEN-1:0] lk, input logic ev,
                      input logic etk, input logic [XLEN-1:0] etgt);
    rst = 0; flush_all = 0; upd_valid = 0; lk_pc = lk;
    #4;
    check_outputs(lk);
    check({tag, "_valid"},  XLEN'(pred_valid), XLEN'(ev));
    check({tag, "_taken"},  XLEN'(pred_taken), XLEN'(etk));
    check({tag, "_target"}, pred_target, etgt);
    @(posedge clk);
    #1;
  endtask

  logic [XLEN-1:0] tops [4];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    look("reset", 32'h100, 0, 0, 32'h0);

    // counter training
    upd(32'h40, 32'h80, 1, BR);
    look("train_hit", 32'h40, 1, 1, 32'h80);
    upd(32'h40, 32'h80, 0, BR);
    upd(32'h40, 32'h80, 0, BR);
    look("train_nt", 32'h40, 1, 0, 32'h80);
    repeat (4) upd(32'h40, 32'h80, 1, BR);
    upd(32'h40, 32'h80, 0, BR);
    look("sat_one_nt", 32'h40, 1, 1, 32'h80);
    upd(32'h40, 32'h80, 0, BR);
    look("sat_two_nt", 32'h40, 1, 0, 32'h80);

    // aliasing and allocation
    look("alias_miss", 32'h440, 0, 0, 32'h0);
    upd(32'h440, 32'h900, 1, JMP);
    look("evicted", 32'h40, 0, 0, 32'h0);
    look("alias_hit", 32'h440, 1, 1, 32'h900);
    upd(32'h0C, 32'h77, 0, BR);
    look("nt_br_noalloc", 32'h0C, 0, 0, 32'h0);

    // RAS return prediction (second CALL on a slot that does not evict the RET)
    upd(32'h200, 32'h600, 1, CALL);
    upd(32'h300, 32'h204, 1, RET);
    look("ret_empty_ras", 32'h300, 1, 1, 32'h204);
    upd(32'h50C, 32'h700, 1, CALL);
    look("ret_from_ras", 32'h300, 1, 1, 32'h510);

    // RAS overflow / underflow
    upd(32'h308, 32'h2000, 1, RET);
    for (int k = 0; k < 5; k++) upd(32'h1000 + 32'(k * 16), 32'h3000, 1, CALL);
    tops[0] = 32'h1044; tops[1] = 32'h1034; tops[2] = 32'h1024; tops[3] = 32'h1014;
    for (int k = 0; k < 4; k++) begin
      look("ras_pop", 32'h308, 1, 1, tops[k]);
      upd(32'h308, 32'h2000, 1, RET);
    end
    look("ras_drained", 32'h308, 1, 1, 32'h2000);
    upd(32'h308, 32'h2000, 1, RET);
    look("ras_underflow", 32'h308, 1, 1, 32'h2000);
    upd(32'h1050, 32'h3000, 1, CALL);
    look("ras_after_uf", 32'h308, 1, 1, 32'h1054);

    // flush beats a same-cycle allocate; reset beats everything
    step(1'b1, 32'h800, 32'h880, 1'b1, JMP, 1'b1, 1'b0, 32'h308);
    look("flush_alloc", 32'h800, 0, 0, 32'h0);
    look("flush_old", 32'h308, 0, 0, 32'h0);
    upd(32'h800, 32'h880, 1, JMP);
    step(1'b1, 32'h904, 32'h990, 1'b1, CALL, 1'b0, 1'b1, 32'h800);
    look("rst_old", 32'h800, 0, 0, 32'h0);
    look("rst_upd", 32'h904, 0, 0, 32'h0);
    upd(32'h308, 32'h2222, 1, RET);
    look("rst_ras_empty", 32'h308, 1, 1, 32'h2222);

    // randomized traffic over a small PC pool so slots alias and hit often
    for (int n = 0; n < 400; n++) begin
      logic [XLEN-1:0] pc, lk, tgt;
      logic uv, tk, fl, rs;
      logic [1:0] ty;
      pc  = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
            | 32'($urandom_range(0, 3));
      lk  = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
      tgt = $urandom;
      uv  = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1) == 1;
      ty  = 2'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 49) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      step(uv, pc, tgt, tk, ty, fl, rs, lk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
